input_debouncer: RTL and testbench

// - Synchronises an asynchronous raw input (button, switch, external strobe) into the clock domain.
// - Rejects bounce and glitches; outputs a clean, debounced level.
// - Sits directly upstream of the edge/pulse generator, which turns level_out into one-cycle pulses.
// - Glitch rejection here guarantees exactly one downstream pulse per real transition.
//

---
 rtl/input_debouncer_if.sv | 18 +
 rtl/input_debouncer.sv | 79 +++++++
 tb/tb_input_debouncer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/input_debouncer_if.sv
// rtl/input_debouncer_if.sv - raw level in, debounced level and settling flag out
interface input_debouncer_if;
    logic level_raw;
    logic level_out;
    logic settling;

    modport master (
        output level_raw,
        input  level_out,
        input  settling
    );

    modport slave (
        input  level_raw,
        output level_out,
        output settling
    );
endinterface

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - synchroniser plus settle-timer FSM producing a clean debounced level
module input_debouncer #(
    parameter int   SYNC_DEPTH    = 2,
    parameter int   STABLE_CYCLES = 1000,
    parameter int   COUNTER_WIDTH = 10,
    parameter logic RESET_VALUE   = 1'b0
) (
    input  logic               clock,
    input  logic               clear,
    input_debouncer_if.slave   deb
);

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] STABLE_MAX = COUNTER_WIDTH'(STABLE_CYCLES);
    localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE  = COUNTER_WIDTH'(1);

    logic [SYNC_DEPTH-1:0]    sync_q;
    logic                     synced;
    state_t                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] count_q, count_d;
    logic                     level_q, level_d;

    assign synced = sync_q[SYNC_DEPTH-1];

    always_ff @(posedge clock) begin
        if (clear) begin
            sync_q  <= {SYNC_DEPTH{RESET_VALUE}};
            state_q <= STABLE;
            count_q <= '0;
            level_q <= RESET_VALUE;
        end else begin
            sync_q  <= {sync_q[SYNC_DEPTH-2:0], deb.level_raw};
            state_q <= state_d;
            count_q <= count_d;
            level_q <= level_d;
        end
    end

    // Any return of synced to the current level restarts timing from zero.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        level_d = level_q;
        case (state_q)
            STABLE: begin
                if (synced != level_q) begin
                    state_d = SETTLING;
                    count_d = COUNT_ONE;
                end else begin
                    count_d = '0;
                end
            end
            SETTLING: begin
                if (synced == level_q) begin
                    state_d = STABLE;
                    count_d = '0;
                end else if (count_q == STABLE_MAX) begin
                    level_d = synced;
                    state_d = STABLE;
                    count_d = '0;
                end else begin
                    count_d = count_q + COUNT_ONE;
                end
            end
            default: begin
                state_d = STABLE;
                count_d = '0;
            end
        endcase
    end

    assign deb.level_out = level_q;
    assign deb.settling  = (state_q == SETTLING);

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - scoreboard bench for three debouncer configurations
module tb_input_debouncer;

    typedef struct {
        int   unit;
        int   cyc;
        logic val;
    } edge_t;

    typedef struct {
        int   unit;
        int   cyc;
        bit   sig;
        logic val;
    } point_t;

    logic   clock = 1'b0;
    logic   clear0, clear1, clear2;
    int     cyc = 0;
    int     checks = 0;
    int     failures = 0;
    logic   done = 1'b0;
    logic   final_done = 1'b0;
    logic [2:0] lvl, stl, prev;
    logic   act_v;
    int     idx;
    edge_t  sb[$];
    point_t pt_q[$];

    input_debouncer_if if0();
    input_debouncer_if if1();
    input_debouncer_if if2();

    input_debouncer #(.SYNC_DEPTH(2), .STABLE_CYCLES(4), .COUNTER_WIDTH(3), .RESET_VALUE(1'b0))
        u0 (.clock(clock), .clear(clear0), .deb(if0.slave));
    input_debouncer #(.SYNC_DEPTH(2), .STABLE_CYCLES(4), .COUNTER_WIDTH(3), .RESET_VALUE(1'b1))
        u1 (.clock(clock), .clear(clear1), .deb(if1.slave));
    input_debouncer u2 (.clock(clock), .clear(clear2), .deb(if2.slave));

    assign lvl = {if2.level_out, if1.level_out, if0.level_out};
    assign stl = {if2.settling, if1.settling, if0.settling};

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: checks due point samples and every observed level_out edge.
    always @(negedge clock) begin
        for (int i = pt_q.size() - 1; i >= 0; i--) begin
            if (pt_q[i].cyc <= cyc) begin
                act_v = pt_q[i].sig ? stl[pt_q[i].unit] : lvl[pt_q[i].unit];
                checks++;
                if (pt_q[i].cyc != cyc || act_v !== pt_q[i].val) begin
                    failures++;
                    $display("FAIL %s unit=%0d cycle=%0d actual=%b required=%b at cycle %0d",
                             pt_q[i].sig ? "settling" : "level_out", pt_q[i].unit, cyc,
                             act_v, pt_q[i].val, pt_q[i].cyc);
                end
                pt_q.delete(i);
            end
        end
        for (int u = 0; u < 3; u++) begin
            if (cyc >= 3 && lvl[u] !== prev[u]) begin
                idx = -1;
                for (int i = 0; i < sb.size(); i++)
                    if (idx < 0 && sb[i].unit == u) idx = i;
                checks++;
                if (idx < 0) begin
                    failures++;
                    $display("FAIL unexpected_edge unit=%0d cycle=%0d actual=%b required=no change",
                             u, cyc, lvl[u]);
                end else begin
                    if (sb[idx].cyc != cyc || sb[idx].val !== lvl[u]) begin
                        failures++;
                        $display("FAIL edge_timing unit=%0d actual cycle=%0d level=%b required cycle=%0d level=%b",
                                 u, cyc, lvl[u], sb[idx].cyc, sb[idx].val);
                    end
                    sb.delete(idx);
                end
            end
            prev[u] = lvl[u];
        end
        if (done && !final_done) begin
            checks++;
            if (sb.size() != 0 || pt_q.size() != 0) begin
                failures++;
                $display("FAIL pending_expectations actual=%0d required=0", sb.size() + pt_q.size());
            end
            final_done = 1'b1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_edge(input int u, input int c, input logic v);
        edge_t e;
        e.unit = u; e.cyc = c; e.val = v;
        sb.push_back(e);
    endtask

    task automatic push_pt(input int u, input int c, input bit s, input logic v);
        point_t p;
        p.unit = u; p.cyc = c; p.sig = s; p.val = v;
        pt_q.push_back(p);
    endtask

    // Clean transition sampled on edge base+1: settling high base+3..base+lat-1, level flips at base+lat.
    task automatic push_clean(input int u, input int base, input logic v, input int lat);
        for (int e = 1; e <= lat; e++)
            push_pt(u, base + e, 1'b1, (e >= 3 && e < lat) ? 1'b1 : 1'b0);
        push_edge(u, base + lat, v);
    endtask

    initial begin
        clear0 = 1'b1; clear1 = 1'b1; clear2 = 1'b1;
        if0.level_raw = 1'b0; if1.level_raw = 1'b1; if2.level_raw = 1'b0;
        push_pt(0, 2, 1'b0, 1'b0); push_pt(0, 2, 1'b1, 1'b0);
        push_pt(1, 2, 1'b0, 1'b1); push_pt(1, 2, 1'b1, 1'b0);
        push_pt(2, 2, 1'b0, 1'b0); push_pt(2, 2, 1'b1, 1'b0);
        step(2);
        clear0 = 1'b0; clear1 = 1'b0; clear2 = 1'b0;
        step(2);

        // Glitch: three high cycles never reach commit.
        if0.level_raw = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            push_pt(0, cyc + e, 1'b1, (e >= 3 && e <= 5) ? 1'b1 : 1'b0);
            push_pt(0, cyc + e, 1'b0, 1'b0);
        end
        step(3);
        if0.level_raw = 1'b0;
        step(8);

        // Clean rise.
        if0.level_raw = 1'b1;
        push_clean(0, cyc, 1'b1, 7);
        step(10);

        // Bounce: toggle every 2 cycles for 20 cycles, then hold high.
        if0.level_raw = 1'b0;
        clear0 = 1'b1;
        push_edge(0, cyc + 1, 1'b0);
        step(2);
        clear0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if0.level_raw = (i % 2 == 0) ? 1'b1 : 1'b0;
            step(2);
        end
        if0.level_raw = 1'b1;
        push_clean(0, cyc, 1'b1, 7);
        step(10);

        // Clear while settling aborts the candidate; release retimes from scratch.
        if0.level_raw = 1'b0;
        clear0 = 1'b1;
        push_edge(0, cyc + 1, 1'b0);
        step(2);
        clear0 = 1'b0;
        step(2);
        if0.level_raw = 1'b1;
        push_pt(0, cyc + 3, 1'b1, 1'b1);
        push_pt(0, cyc + 4, 1'b1, 1'b1);
        step(4);
        clear0 = 1'b1;
        push_pt(0, cyc + 1, 1'b0, 1'b0);
        push_pt(0, cyc + 1, 1'b1, 1'b0);
        step(1);
        clear0 = 1'b0;
        push_clean(0, cyc, 1'b1, 7);
        step(10);

        // RESET_VALUE=1 unit: stays high with raw high, then falls.
        for (int e = 1; e <= 4; e++) push_pt(1, cyc + e, 1'b1, 1'b0);
        step(4);
        if1.level_raw = 1'b0;
        push_clean(1, cyc, 1'b0, 7);
        step(10);

        // Default build: commit on edge 1003.
        if2.level_raw = 1'b1;
        push_clean(2, cyc, 1'b1, 1003);
        step(1006);

        done = 1'b1;
        for (int i = 0; i < 5 && !final_done; i++) step(1);
        if (!final_done) begin
            $display("FAIL monitor_final actual=not reached required=reached");
            $fatal(1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
